// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between I-fill, D-fill and write-through stores.
// Define ARB_TIMEOUT_EN to abort fills that stall and raise the sticky arb_err flag.
module mem_arbiter #(
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [15:0]      i_addr,
  input  logic             d_req,
  input  logic [15:0]      d_addr,
  input  logic             w_req,
  input  logic [15:0]      w_addr,
  input  logic [15:0]      w_data,
  input  logic             mem_data_valid,
  output logic             i_gnt,
  output logic             d_gnt,
  output logic             w_ack,
  output logic             i_valid,
  output logic             d_valid,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             arb_err
);

  typedef enum logic [1:0] {S_IDLE, S_FILL_I, S_FILL_D, S_WRITE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_beat;
  logic             r_last_d;
  logic             w_last_beat;
  logic             w_tmo;

  assign w_last_beat = mem_data_valid && (r_beat == CNT_W'(LINE_WORDS - 1));

`ifdef ARB_TIMEOUT_EN
  logic       w_fill;
  logic [6:0] r_idle;
  logic       r_err;

  assign w_fill  = (r_state == S_FILL_I) || (r_state == S_FILL_D);
  // A beat landing on the final idle cycle still counts; only a silent cycle aborts.
  assign w_tmo   = w_fill && !mem_data_valid && (r_idle == 7'(TIMEOUT - 1));
  assign arb_err = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
      r_err  <= 1'b0;
    end else begin
      if (!w_fill || mem_data_valid || w_tmo)
        r_idle <= '0;
      else
        r_idle <= r_idle + 7'd1;
      if (w_tmo)
        r_err <= 1'b1;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_last_d <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Stores win; simultaneous fills alternate away from the last one served.
          if (w_req)
            r_state <= S_WRITE;
          else if (i_req && d_req)
            r_state <= r_last_d ? S_FILL_I : S_FILL_D;
          else if (i_req)
            r_state <= S_FILL_I;
          else if (d_req)
            r_state <= S_FILL_D;
        end
        S_FILL_I, S_FILL_D: begin
          if (w_last_beat || w_tmo) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_last_d <= (r_state == S_FILL_D);
          end else if (mem_data_valid) begin
            r_beat <= r_beat + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    w_ack     = 1'b0;
    i_valid   = 1'b0;
    d_valid   = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_FILL_I: begin
        i_gnt    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = i_addr;
        i_valid  = mem_data_valid;
      end
      S_FILL_D: begin
        d_gnt    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = d_addr;
        d_valid  = mem_data_valid;
      end
      S_WRITE: begin
        w_ack     = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = w_addr;
        mem_wdata = w_data;
      end
      default: ;
    endcase
  end

  assign beat_cnt = r_beat;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized requester/memory stimulus, transaction-order model.
module tb_mem_arbiter;
  localparam int LINE_WORDS = 8;
  localparam int CNT_W      = 3;
  localparam int TIMEOUT    = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_req = 1'b0, d_req = 1'b0, w_req = 1'b0, mem_data_valid = 1'b0;
  logic [15:0]      i_addr = '0, d_addr = '0, w_addr = '0, w_data = '0;
  logic             i_gnt, d_gnt, w_ack, i_valid, d_valid, mem_en, mem_wr, arb_err;
  logic [15:0]      mem_addr, mem_wdata;
  logic [CNT_W-1:0] beat_cnt;

  mem_arbiter #(.LINE_WORDS(LINE_WORDS), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .d_req(d_req), .d_addr(d_addr),
    .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .mem_data_valid(mem_data_valid),
    .i_gnt(i_gnt), .d_gnt(d_gnt), .w_ack(w_ack), .i_valid(i_valid), .d_valid(d_valid),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .beat_cnt(beat_cnt), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  // kind: 1 = I beat, 2 = D beat, 3 = store
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    int          beat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Requester/memory model state
  logic s_i_gnt, s_d_gnt, s_w_ack, s_i_valid, s_d_valid;
  int   i_beats, d_beats;
  bit   inj_arm   = 1'b0;
  bit   mem_quiet = 1'b0;
  bit   model_last_d = 1'b1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void push_fill(input int kind, input logic [15:0] base);
    exp_t e;
    for (int k = 0; k < LINE_WORDS; k++) begin
      e.kind = kind;
      e.addr = base + 16'(2 * k);
      e.data = '0;
      e.beat = k;
      exp_q.push_back(e);
    end
  endfunction

  function automatic void push_store(input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.kind = 3;
    e.addr = a;
    e.data = d;
    e.beat = 0;
    exp_q.push_back(e);
  endfunction

  // Monitor: checks every cycle, pops the scoreboard whenever a transaction is presented.
  initial begin : monitor
    int   own;
    int   prev_own;
    exp_t e;
    prev_own = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_own = 0;
      end else begin
        own = 0;
        if (i_gnt) own = 1;
        else if (d_gnt) own = 2;
        else if (w_ack) own = 3;
        if (own != 0 && own != prev_own)
          chk("turnaround_prev_owner", 32'(prev_own), 32'd0);
        prev_own = own;
        chk("gnt_exclusive", 32'(i_gnt & d_gnt), 32'd0);
        chk("valid_gating", 32'({i_valid, d_valid}),
            32'({mem_data_valid & i_gnt, mem_data_valid & d_gnt}));
        if (!i_gnt && !d_gnt)
          chk("beat_cnt_outside_fill", 32'(beat_cnt), 32'd0);
        if (i_valid || d_valid || w_ack) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_txn: owner %0d presented, expected none at %0t", own, $time);
          end else begin
            e = exp_q.pop_front();
            chk("txn_kind", 32'(own), 32'(e.kind));
            chk("mem_addr", 32'(mem_addr), 32'(e.addr));
            chk("mem_en", 32'(mem_en), 32'd1);
            if (e.kind == 3) begin
              chk("mem_wr_store", 32'(mem_wr), 32'd1);
              chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
            end else begin
              chk("mem_wr_fill", 32'(mem_wr), 32'd0);
              chk("beat_cnt", 32'(beat_cnt), 32'(e.beat));
            end
          end
        end
      end
    end
  end

  // One clock of requester and memory behaviour; returns at posedge + 1.
  task automatic step();
    @(negedge clk);
    s_i_gnt   = i_gnt;
    s_d_gnt   = d_gnt;
    s_w_ack   = w_ack;
    s_i_valid = i_valid;
    s_d_valid = d_valid;
    @(posedge clk);
    #1;
    if (w_req && s_w_ack) w_req = 1'b0;
    if (i_req && s_i_gnt) i_req = 1'b0;
    if (d_req && s_d_gnt) d_req = 1'b0;
    if (s_i_valid) begin i_addr = i_addr + 16'd2; i_beats++; end
    if (s_d_valid) begin d_addr = d_addr + 16'd2; d_beats++; end
    if (inj_arm && (i_beats + d_beats) == 3) begin
      w_req   = 1'b1;
      inj_arm = 1'b0;
    end
    if (mem_quiet)
      mem_data_valid = 1'b0;
    else if (s_i_gnt || s_d_gnt)
      mem_data_valid = ($urandom_range(0, 2) == 0);
    else
      mem_data_valid = ($urandom_range(0, 3) == 0);
  endtask

  task automatic run_scn(input bit dw, input bit di, input bit dd, input bit inj);
    logic [15:0] ib, db, wa, wd;
    int first, second, cyc;
    ib = 16'($urandom) & 16'hFFFE;
    db = 16'($urandom) & 16'hFFFE;
    wa = 16'($urandom);
    wd = 16'($urandom);
    first  = 0;
    second = 0;
    if (di && dd) begin
      first  = model_last_d ? 1 : 2;
      second = 3 - first;
    end else if (di) first = 1;
    else if (dd) first = 2;
    if (dw) push_store(wa, wd);
    if (first != 0) push_fill(first, (first == 1) ? ib : db);
    if (inj && !dw && first != 0) push_store(wa, wd);
    if (second != 0) push_fill(second, (second == 1) ? ib : db);
    if (second != 0) model_last_d = (second == 2);
    else if (first != 0) model_last_d = (first == 2);
    i_addr = ib; d_addr = db; w_addr = wa; w_data = wd;
    i_beats = 0; d_beats = 0;
    i_req = di; d_req = dd; w_req = dw;
    inj_arm = inj && !dw && (first != 0);
    cyc = 0;
    while ((exp_q.size() != 0 || i_req || d_req || w_req || inj_arm) && cyc < 3000) begin
      step();
      cyc++;
    end
    if (cyc >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL scenario_timeout: %0d entries left after %0d cycles", exp_q.size(), cyc);
      exp_q.delete();
    end
    step();
    step();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish, %0d entries left", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cyc, gcyc;
    logic [15:0] last_addr;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_grants", 32'({i_gnt, d_gnt, w_ack}), 32'd0);
    chk("rst_valids", 32'({i_valid, d_valid}), 32'd0);
    chk("rst_mem_ctl", 32'({mem_en, mem_wr}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_arb_err", 32'(arb_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed: contention twice (I, D, then D, I), store vs fill, store during fill, lone I
    run_scn(1'b0, 1'b1, 1'b1, 1'b0);
    run_scn(1'b0, 1'b1, 1'b1, 1'b0);
    run_scn(1'b1, 1'b0, 1'b1, 1'b0);
    run_scn(1'b0, 1'b1, 1'b0, 1'b1);
    run_scn(1'b1, 1'b1, 1'b1, 1'b0);
    run_scn(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized mixes
    for (int n = 0; n < 30; n++) begin
      logic [2:0] m;
      m = 3'($urandom_range(1, 7));
      run_scn(m[2], m[1], m[0], 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an I fill, at beat 5
    push_fill(1, 16'h0100);
    i_addr = 16'h0100; i_beats = 0; d_beats = 0; i_req = 1'b1;
    cyc = 0;
    while (i_beats < 5 && cyc < 500) begin step(); cyc++; end
    chk("midfill_beats_reached", 32'(i_beats), 32'd5);
    #2 rst = 1'b0;
    #1;
    last_addr = i_addr;
    chk("midrst_grants", 32'({i_gnt, d_gnt, w_ack}), 32'd0);
    chk("midrst_valids", 32'({i_valid, d_valid}), 32'd0);
    chk("midrst_mem_ctl", 32'({mem_en, mem_wr}), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("midrst_i_addr_held", 32'(last_addr), 32'h010A);
    exp_q.delete();
    i_req = 1'b0;
    mem_data_valid = 1'b0;
    model_last_d = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    // After reset, I must win the tie again
    run_scn(1'b0, 1'b1, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // D fill whose memory never answers
    mem_quiet = 1'b1;
    push_fill(2, 16'h4000);
    d_addr = 16'h4000; d_req = 1'b1; i_beats = 0; d_beats = 0;
    cyc = 0; gcyc = 0;
    while (cyc < 300 && !(gcyc > 0 && !s_d_gnt)) begin
      step();
      if (s_d_gnt) gcyc++;
      cyc++;
    end
    chk("timeout_grant_cycles", 32'(gcyc), 32'(TIMEOUT));
    chk("timeout_arb_err", 32'(arb_err), 32'd1);
    chk("timeout_gnt_dropped", 32'(d_gnt), 32'd0);
    exp_q.delete();
    mem_quiet = 1'b0;
    model_last_d = 1'b1;
    run_scn(1'b0, 1'b1, 1'b1, 1'b0);
    chk("arb_err_sticky", 32'(arb_err), 32'd1);
`else
    gcyc = 0;
    chk("arb_err_disabled", 32'(arb_err), 32'(gcyc));
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single main-memory port between the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores.
- Grants one requester at a time and routes the address, data, enable and write signals to memory.
- Routes memory_data_valid back to the granted fill requester only.
- Holds each fill grant until all line beats have returned; the two fill requesters are served round-robin.

Parameters:
- LINE_WORDS, 8: data beats per cache-line fill.
- CNT_W, 3: beat-counter width, equal to clog2(LINE_WORDS).
- TIMEOUT, 64: cycles without a valid beat before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- i_req  in  1  I-fill requests memory; held high until i_gnt.
- i_addr  in  16  I-fill address; the requester increments it by 2 per beat.
- d_req  in  1  D-fill request.
- d_addr  in  16  D-fill address.
- w_req  in  1  store write request.
- w_addr  in  16  store address.
- w_data  in  16  store data.
- mem_data_valid  in  1  memory read data valid.
- i_gnt  out  1  I-fill owns memory.
- d_gnt  out  1  D-fill owns memory.
- w_ack  out  1  one-cycle pulse: store accepted.
- i_valid  out  1  mem_data_valid gated to the I side.
- d_valid  out  1  mem_data_valid gated to the D side.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- beat_cnt  out  CNT_W  beats received in the current fill.
- arb_err  out  1  sticky timeout flag; held 0 when the feature is compiled out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, last_fill=D, so I wins the first tie.
  - beat_cnt=0, arb_err=0.
  - All grants, w_ack, i_valid, d_valid, mem_en and mem_wr are 0.
  - mem_addr and mem_wdata are 0.
- State register, beat counter and last_fill are registered. All outputs are combinational from the state and the inputs.
- States: IDLE, FILL_I, FILL_D, WRITE.
- IDLE:
  - Outputs are idle.
  - Priority: w_req first, then the fill requesters.
  - w_req=1 -> WRITE.
  - Otherwise, if only one fill request is high, go to that fill state.
  - If both fill requests are high, grant the requester not equal to last_fill.
  - Decisions are registered, so a grant appears the cycle after the request.
- FILL_I / FILL_D:
  - Drive: gnt=1, mem_en=1, mem_wr=0, mem_addr = the granted requester's address.
  - valid of the granted side = mem_data_valid; the other side's valid is 0.
  - Each mem_data_valid increments beat_cnt, wrapping mod LINE_WORDS.
  - On the beat where beat_cnt==LINE_WORDS-1 and mem_data_valid=1: go to IDLE, set beat_cnt=0, set last_fill = the current side.
  - w_req arriving mid-fill waits; a fill is never pre-empted.
- WRITE:
  - One cycle: mem_en=1, mem_wr=1, mem_addr=w_addr, mem_wdata=w_data, w_ack=1.
  - Next state is IDLE.
  - The requester drops w_req after seeing w_ack; a still-high w_req in IDLE is treated as a new store.
- Turnaround: at least one IDLE cycle between any two grants.
- mem_data_valid seen in IDLE or WRITE is ignored and not counted; both valid outputs stay 0.
- The granting side's req is not required to stay high during a fill; the grant ends only on beat completion (or timeout).
- A reset asserted mid-fill aborts immediately to IDLE. The requester FSM, reset by the same rst, restarts cleanly.
- Both fill requests plus w_req in the same cycle: WRITE first, then the round-robin fill, then the other fill.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A 7-bit idle counter runs in FILL_I/FILL_D and clears on every mem_data_valid.
  - On reaching TIMEOUT-1, the arbiter sets arb_err (sticky until reset), drops the grant, and returns to IDLE with beat_cnt=0.
  - last_fill is updated as for a completed fill.
- ARB_TIMEOUT_EN undefined: no counter; a fill waits forever; arb_err is tied to 0.

Test Plan:
- I-fill alone:
  - Stimulus: i_req=1, i_addr=0x0100 stepping by 2, 8 valid beats spaced 4 cycles apart.
  - Response: i_gnt high for the whole fill; i_valid pulses 8 times; d_valid=0; mem_addr sequence 0x0100..0x010E; IDLE after the 8th beat.
- Contention:
  - Stimulus: i_req and d_req rise together after reset.
  - Response: I granted first; D granted after the I fill completes plus 1 IDLE cycle. Repeated contention alternates D, then I.
- Store priority:
  - Stimulus: w_req=1 (w_addr=0x2000, w_data=0xBEEF) while an I fill is at beat 3.
  - Response: no pre-emption; after beat 8 plus 1 IDLE cycle, one-cycle mem_wr=1, mem_addr=0x2000, mem_wdata=0xBEEF, w_ack=1.
- Store versus fill:
  - Stimulus: w_req and d_req high together in IDLE.
  - Response: WRITE first, then FILL_D.
- Stray data:
  - Stimulus: mem_data_valid=1 while in IDLE.
  - Response: beat_cnt stays 0; i_valid=d_valid=0.
- Reset mid-fill and timeout:
  - Reset mid-fill: rst=0 at beat 5 -> all outputs 0 asynchronously; beat_cnt=0.
  - With ARB_TIMEOUT_EN: no valid beat for 64 cycles -> arb_err=1, grant dropped, return to IDLE.
